blc_frame_min_tracker: RTL and testbench

//  Streaming per-channel minimum tracker for black-level estimation.

---
 rtl/blc_frame_min_tracker.sv | 92 +++++++++
 tb/tb_blc_frame_min_tracker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/blc_frame_min_tracker.sv
// blc_frame_min_tracker: per-Bayer-channel running minimum and sample count per frame.
// Optional BLC_MIN_REJECT_ZERO_EN: zero-valued pixels are skipped for min/count.
module blc_frame_min_tracker #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_sof,
    input  logic                           in_eol,
    input  logic                           in_eof,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]   out_min,
    output logic [NUM_CH*CNT_WIDTH-1:0]    out_cnt,
    output logic [NUM_CH-1:0]              out_empty
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t                state;
    logic                  row_par, col_par, cur_row, cur_col, accept;
    logic                  s1_valid, s1_sof, s1_eof, s1_use;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [CH_W-1:0]       cur_ch, s1_ch;
    logic [DATA_WIDTH-1:0] mins [NUM_CH];
    logic [CNT_WIDTH-1:0]  cnts [NUM_CH];
    assign in_ready  = (state != DONE) && !(s1_valid && s1_eof);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    // sof restarts the parity raster so the first pixel is always ch0
    assign cur_row = in_sof ? 1'b0 : row_par;
    assign cur_col = in_sof ? 1'b0 : col_par;
    assign cur_ch  = (NUM_CH == 4) ? CH_W'({cur_row, cur_col}) :
                     (NUM_CH == 2) ? CH_W'(cur_col) : '0;
`ifdef BLC_MIN_REJECT_ZERO_EN
    assign s1_use = (s1_data != '0);
`else
    assign s1_use = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            row_par  <= 1'b0;
            col_par  <= 1'b0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_ch    <= '0;
            s1_sof   <= 1'b0;
            s1_eof   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                mins[k] <= '1;
                cnts[k] <= '0;
            end
        end else begin
            if (accept) begin
                col_par <= in_eol ? 1'b0 : ~cur_col;
                row_par <= cur_row ^ in_eol;
            end
            s1_valid <= accept && (in_sof || state == ACC);
            s1_data  <= in_data;
            s1_ch    <= cur_ch;
            s1_sof   <= in_sof;
            s1_eof   <= in_eof;
            if (state == IDLE && accept && in_sof)
                state <= ACC;
            else if (state == ACC && s1_valid && s1_eof)
                state <= DONE;
            else if (state == DONE && out_ready)
                state <= IDLE;
            // sof wipes every channel; the sof pixel then lands as the first sample
            for (int k = 0; k < NUM_CH; k++) begin
                if (s1_valid && s1_sof) begin
                    mins[k] <= '1;
                    cnts[k] <= '0;
                end
                if (s1_valid && s1_use && CH_W'(k) == s1_ch) begin
                    mins[k] <= (s1_sof || s1_data < mins[k]) ? s1_data : mins[k];
                    cnts[k] <= s1_sof ? CNT_WIDTH'(1) : cnts[k] + CNT_WIDTH'(!(&cnts[k]));
                end
            end
        end
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign out_min[(NUM_CH-1-g)*DATA_WIDTH +: DATA_WIDTH] = mins[g];
        assign out_cnt[(NUM_CH-1-g)*CNT_WIDTH +: CNT_WIDTH]   = cnts[g];
        assign out_empty[NUM_CH-1-g]                          = (cnts[g] == '0);
    end
endmodule

// File: tb/tb_blc_frame_min_tracker.sv
// tb_blc_frame_min_tracker: scoreboarded random and directed frames against a raster-level model.
module tb_blc_frame_min_tracker;
    localparam int NC = 4, DW = 8, CW = 24;
`ifdef BLC_MIN_REJECT_ZERO_EN
    localparam bit REJ = 1'b1;
`else
    localparam bit REJ = 1'b0;
`endif
    typedef struct packed {
        logic [NC*DW-1:0] mn;
        logic [NC*CW-1:0] cnt;
        logic [NC-1:0]    emp;
    } res_t;
    logic clk = 0, rst = 1, in_valid = 0, in_sof = 0, in_eol = 0, in_eof = 0, out_ready = 0;
    logic in_ready, out_valid;
    logic [DW-1:0] in_data = 0;
    logic [NC*DW-1:0] out_min;
    logic [NC*CW-1:0] out_cnt;
    logic [NC-1:0] out_empty;
    int checks = 0, errors = 0;
    bit force_hold = 0, held = 0;
    res_t sb[$];
    res_t snap, cur, exp_r;
    int pix[$];

    blc_frame_min_tracker #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sof(in_sof), .in_eol(in_eol), .in_eof(in_eof), .out_valid(out_valid),
        .out_ready(out_ready), .out_min(out_min), .out_cnt(out_cnt), .out_empty(out_empty));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = force_hold ? 1'b0 : ($urandom % 4 != 0);
    end

    always @(negedge clk) begin
        cur = {out_min, out_cnt, out_empty};
        if (rst) held = 0;
        else if (out_valid) begin
            chk("in_ready_in_done", in_ready, 0);
            if (held) chk("hold_stable", cur, snap);
            if (out_ready) begin
                if (sb.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    exp_r = sb.pop_front();
                    chk("out_min", out_min, exp_r.mn);
                    chk("out_cnt", out_cnt, exp_r.cnt);
                    chk("out_empty", out_empty, exp_r.emp);
                end
                held = 0;
            end else begin
                snap = cur;
                held = 1;
            end
        end
    end

    function automatic res_t model(input int w, input int h);
        int mn[NC], cn[NC], r, c, ch;
        res_t res;
        for (int k = 0; k < NC; k++) begin mn[k] = 2**DW - 1; cn[k] = 0; end
        for (int i = 0; i < w*h; i++) begin
            r = i / w;
            c = i % w;
            ch = (NC == 4) ? (r % 2) * 2 + (c % 2) : (NC == 2) ? c % 2 : 0;
            if (!(REJ && pix[i] == 0)) begin
                cn[ch]++;
                if (pix[i] < mn[ch]) mn[ch] = pix[i];
            end
        end
        for (int k = 0; k < NC; k++) begin
            res.mn[(NC-1-k)*DW +: DW] = DW'(mn[k]);
            res.cnt[(NC-1-k)*CW +: CW] = CW'(cn[k]);
            res.emp[NC-1-k] = (cn[k] == 0);
        end
        return res;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_beat(input int d, input bit s, input bit l, input bit e);
        int n = 0;
        in_valid = 1; in_data = DW'(d); in_sof = s; in_eol = l; in_eof = e;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) chk("beat_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 0; in_sof = 0; in_eol = 0; in_eof = 0; in_data = DW'($urandom);
    endtask

    task automatic send_frame(input int w, input int h, input int lim, input bit bub);
        for (int i = 0; i < w*h && i < lim; i++) begin
            if (i == w*h - 1) sb.push_back(model(w, h));
            if (bub && $urandom % 3 == 0) idle(1 + $urandom % 2);
            send_beat(pix[i], i == 0, i % w == w - 1, i == w*h - 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_pix(input int n, input int lo);
        pix.delete();
        for (int i = 0; i < n; i++)
            pix.push_back(($urandom % 4 == 0) ? lo + $urandom % 8 : lo + $urandom % (256 - lo));
    endtask

    initial begin
        idle(3);
        rst = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_min", out_min, {NC*DW{1'b1}});
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_out_empty", out_empty, {NC{1'b1}});
        @(posedge clk);
        #1;
        pix = '{10, 20, 30, 40};
        send_frame(2, 2, 99, 0);
        @(negedge clk);
        chk("latency_t1", out_valid, 0);
        @(negedge clk);
        chk("latency_t2", out_valid, 1);
        chk("t1_min", out_min, 32'h0a141e28);
        @(posedge clk);
        #1;
        drain();
        force_hold = 1;
        idle(2);
        rand_pix(16, 100);
        pix[1] = 50; pix[3] = 7; pix[9] = 7; pix[11] = 90;
        send_frame(4, 4, 99, 1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("t2_ch1_min", out_min[2*DW +: DW], 7);
            chk("t2_ch1_cnt", out_cnt[2*CW +: CW], 4);
            @(negedge clk);
        end
        force_hold = 0;
        @(posedge clk);
        #1;
        pix = '{5, 1, 9};
        send_frame(4, 4, 3, 1);
        rand_pix(16, 2);
        send_frame(4, 4, 99, 1);
        pix = '{33};
        send_frame(1, 1, 99, 0);
        pix = '{0, 20, 5, 30, 40, 50, 60, 70};
        send_frame(4, 2, 99, 0);
        drain();
        rand_pix(12, 0);
        send_frame(4, 3, 3, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_cnt", out_cnt, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        for (int f = 0; f < 30; f++) begin
            int w, h;
            w = 1 + $urandom % 6;
            h = 1 + $urandom % 5;
            if ($urandom % 4 == 0) send_beat($urandom, 0, $urandom % 2, $urandom % 2);
            rand_pix(w * h, 0);
            send_frame(w, h, 99, 1);
        end
        drain();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
